register_file_sb: RTL and testbench

Clocked, parametrised successor to the processor's combinational register bank. It provides a DATA_W x NUM_REGS register file with two read ports, an ALU writeback port and a load writeback port. A per-register pending-load scoreboard marks registers awaiting load data, and a registered NZCV flags register is included. It sits between the instruction decoder/issue logic, the ALU and memory control, and replaces the existing decoder + bank + read-mux trio.

---
 rtl/register_file_sb_pkg.sv | 15 +
 rtl/rf_read_port.sv | 53 +++++
 rtl/register_file_sb.sv | 129 ++++++++++++
 tb/tb_register_file_sb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared constants for the clocked register file slice.
//   - NZCV flag bit positions within flags_in / flags_out.
//   - Default geometry used by register_file_sb and rf_read_port.
package register_file_sb_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = 4;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of register_file_sb.
// Ports:
//   sel          register select
//   regs_flat    all registers, register i at [i*DATA_W +: DATA_W]
//   pending      scoreboard vector
//   alu_wr/...   ALU write accepted this cycle, its destination and data
//   ld_wr/...    load return accepted this cycle, its destination and data
//   ld_reissue   the returning register is reissued in the same cycle
//   data, busy   read data and pending-load indication for sel
module rf_read_port
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0]          sel,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [NUM_REGS-1:0]        pending,
    input  logic                       alu_wr,
    input  logic [ADDR_W-1:0]          alu_dest,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_wr,
    input  logic [ADDR_W-1:0]          ld_wdest,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_reissue,
    output logic [DATA_W-1:0]          data,
    output logic                       busy
);

    // NOTE: every output gets a value before any condition so no latch is inferred.
    always_comb begin
        data = regs_flat[sel*DATA_W +: DATA_W];
        busy = pending[sel];
        if (BYPASS) begin
            // A returning load and an accepted ALU write never share a
            // destination, so at most one of these forwards.
            if (ld_wr && (ld_wdest == sel)) begin
                data = ld_data;
                busy = ld_reissue;
            end else if (alu_wr && (alu_dest == sel)) begin
                data = alu_data;
            end
        end
        if (ZERO_REG && (sel == '0)) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Clocked register file with two combinational read ports, ALU and load
// writeback ports, a pending-load scoreboard and a registered NZCV flags word.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   rd_sel*/rd_data*      read selects and combinational read data
//   rd_busy*              read source awaits load data
//   alu_we/dest/data      ALU writeback
//   ld_issue/ld_dest      load issue reservation, ld_issue_ok = accepted
//   ld_we/wdest/data      load data return
//   flags_we/in/out       NZCV flags update and registered value
//   pending               scoreboard vector
//   hazard_err            sticky protocol violation
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_sel1,
    input  logic [ADDR_W-1:0]   rd_sel2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    input  logic                alu_we,
    input  logic [ADDR_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_issue,
    input  logic [ADDR_W-1:0]   ld_dest,
    output logic                ld_issue_ok,
    input  logic                ld_we,
    input  logic [ADDR_W-1:0]   ld_wdest,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                flags_we,
    input  logic [3:0]          flags_in,
    output logic [3:0]          flags_out,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard_err
);

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        pending_nxt;

    logic alu_zero, ld_zero, ld_wzero;
    logic ld_match, ld_ret_ok, ld_ret_err;
    logic alu_hit, alu_err, alu_wr, ld_reissue, set_pend;

    // Register 0 targets are silently ignored when it is hardwired to zero.
    assign alu_zero = ZERO_REG && (alu_dest == '0);
    assign ld_zero  = ZERO_REG && (ld_dest == '0);
    assign ld_wzero = ZERO_REG && (ld_wdest == '0);

    assign ld_match    = ld_we && (ld_wdest == ld_dest);
    assign ld_issue_ok = ld_issue && (!pending[ld_dest] || ld_match);
    assign ld_reissue  = ld_issue_ok && ld_match;
    assign set_pend    = ld_issue_ok && !ld_zero;

    assign ld_ret_ok  = ld_we && !ld_wzero && pending[ld_wdest];
    assign ld_ret_err = ld_we && !ld_wzero && !pending[ld_wdest];

    // The load owns any register it returns to, so an ALU write to the same
    // destination is a protocol error even when the load itself is bogus.
    assign alu_hit = alu_we && !alu_zero;
    assign alu_err = alu_hit && (pending[alu_dest] || (ld_we && (ld_wdest == alu_dest)));
    assign alu_wr  = alu_hit && !alu_err;

    always_comb begin
        pending_nxt = pending;
        if (ld_ret_ok) pending_nxt[ld_wdest] = 1'b0;
        // A same-cycle reissue keeps the reservation alive.
        if (set_pend) pending_nxt[ld_dest] = 1'b1;
    end

    // NOTE: the register array is reset as well, because software may rely on
    // reading zeros from registers never written since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (alu_wr) regs[alu_dest] <= alu_data;
            if (ld_ret_ok) regs[ld_wdest] <= ld_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            flags_out  <= '0;
            hazard_err <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            hazard_err <= hazard_err | alu_err | ld_ret_err;
            if (flags_we) flags_out <= flags_in;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port1 (
        .sel(rd_sel1), .regs_flat(regs_flat), .pending(pending),
        .alu_wr(alu_wr), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_wr(ld_ret_ok), .ld_wdest(ld_wdest), .ld_data(ld_data),
        .ld_reissue(ld_reissue), .data(rd_data1), .busy(rd_busy1)
    );

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port2 (
        .sel(rd_sel2), .regs_flat(regs_flat), .pending(pending),
        .alu_wr(alu_wr), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_wr(ld_ret_ok), .ld_wdest(ld_wdest), .ld_data(ld_data),
        .ld_reissue(ld_reissue), .data(rd_data2), .busy(rd_busy2)
    );

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_sel1, rd_sel2, alu_dest, ld_dest, ld_wdest, flags_in;
    logic [31:0] alu_data, ld_data;
    logic        alu_we, ld_issue, ld_we, flags_we;

    logic [31:0] rd_data1, rd_data2, nb_rd_data1, nb_rd_data2;
    logic        rd_busy1, rd_busy2, nb_rd_busy1, nb_rd_busy2;
    logic        ld_issue_ok, nb_ld_issue_ok, hazard_err, nb_hazard_err;
    logic [3:0]  flags_out, nb_flags_out;
    logic [15:0] pending, nb_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk(clk), .rst(rst),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .alu_we(alu_we), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_dest(ld_dest), .ld_issue_ok(ld_issue_ok),
        .ld_we(ld_we), .ld_wdest(ld_wdest), .ld_data(ld_data),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(flags_out),
        .pending(pending), .hazard_err(hazard_err)
    );

    // Same stimulus, forwarding disabled.
    register_file_sb #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
        .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
        .alu_we(alu_we), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_dest(ld_dest), .ld_issue_ok(nb_ld_issue_ok),
        .ld_we(ld_we), .ld_wdest(ld_wdest), .ld_data(ld_data),
        .flags_we(flags_we), .flags_in(flags_in), .flags_out(nb_flags_out),
        .pending(nb_pending), .hazard_err(nb_hazard_err)
    );

    typedef struct {
        logic        aw;  logic [3:0] ad;  logic [31:0] adata;
        logic        li;  logic [3:0] ldd;
        logic        lw;  logic [3:0] lwd; logic [31:0] ldata;
        logic        fw;  logic [3:0] fi;
        logic [3:0]  s1;  logic [3:0] s2;
        logic [31:0] r1;  logic [31:0] r2; logic [31:0] nb2;
        logic        b1;  logic b2; logic ok;
        logic [15:0] p;   logic h;  logic [3:0] f;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic aw, input logic [3:0] ad, input logic [31:0] adata,
        input logic li, input logic [3:0] ldd,
        input logic lw, input logic [3:0] lwd, input logic [31:0] ldata,
        input logic fw, input logic [3:0] fi,
        input logic [3:0] s1, input logic [3:0] s2,
        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] nb2,
        input logic b1, input logic b2, input logic ok,
        input logic [15:0] p, input logic h, input logic [3:0] f);
        vec_t v;
        v.aw = aw; v.ad = ad; v.adata = adata; v.li = li; v.ldd = ldd;
        v.lw = lw; v.lwd = lwd; v.ldata = ldata; v.fw = fw; v.fi = fi;
        v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2; v.nb2 = nb2;
        v.b1 = b1; v.b2 = b2; v.ok = ok; v.p = p; v.h = h; v.f = f;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_we = 0; alu_dest = 0; alu_data = 0;
        ld_issue = 0; ld_dest = 0; ld_we = 0; ld_wdest = 0; ld_data = 0;
        flags_we = 0; flags_in = 0;
    endtask

    task automatic apply(input vec_t v);
        alu_we = v.aw; alu_dest = v.ad; alu_data = v.adata;
        ld_issue = v.li; ld_dest = v.ldd;
        ld_we = v.lw; ld_wdest = v.lwd; ld_data = v.ldata;
        flags_we = v.fw; flags_in = v.fi;
        rd_sel1 = v.s1; rd_sel2 = v.s2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        //           aw ad adata         li ldd lw lwd ldata        fw fi     s1 s2 r1            r2            nb2           b1 b2 ok p        h  f
        vecs[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 4'h0,  3, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 16'h0000, 0, 4'h0);
        vecs[1]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 4'h0,  3, 5, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 16'h0000, 0, 4'h0);
        vecs[2]  = mk(1, 5, 32'h12,       0, 0, 0, 0, 32'h0,        0, 4'h0,  3, 5, 32'hDEADBEEF, 32'h12,       32'h0,        0, 0, 0, 16'h0000, 0, 4'h0);
        vecs[3]  = mk(0, 0, 32'h0,        1, 7, 0, 0, 32'h0,        0, 4'h0,  7, 5, 32'h0,        32'h12,       32'h12,       0, 0, 1, 16'h0080, 0, 4'h0);
        vecs[4]  = mk(0, 0, 32'h0,        1, 7, 0, 0, 32'h0,        0, 4'h0,  7, 5, 32'h0,        32'h12,       32'h12,       1, 0, 0, 16'h0080, 0, 4'h0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0, 1, 7, 32'hA5A5,     0, 4'h0,  7, 5, 32'hA5A5,     32'h12,       32'h12,       0, 0, 0, 16'h0000, 0, 4'h0);
        vecs[6]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 4'h0,  7, 3, 32'hA5A5,     32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 16'h0000, 0, 4'h0);
        vecs[7]  = mk(0, 0, 32'h0,        1, 4, 0, 0, 32'h0,        0, 4'h0,  4, 3, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 16'h0010, 0, 4'h0);
        vecs[8]  = mk(1, 4, 32'h99,       0, 0, 0, 0, 32'h0,        0, 4'h0,  4, 4, 32'h0,        32'h0,        32'h0,        1, 1, 0, 16'h0010, 1, 4'h0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 4'h0,  4, 3, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 16'h0010, 1, 4'h0);
        vecs[10] = mk(0, 0, 32'h0,        0, 0, 1, 4, 32'h44,       0, 4'h0,  4, 4, 32'h44,       32'h44,       32'h0,        0, 0, 0, 16'h0000, 1, 4'h0);
        vecs[11] = mk(0, 0, 32'h0,        1, 9, 0, 0, 32'h0,        0, 4'h0,  9, 4, 32'h0,        32'h44,       32'h44,       0, 0, 1, 16'h0200, 1, 4'h0);
        vecs[12] = mk(0, 0, 32'h0,        1, 9, 1, 9, 32'h9999,     0, 4'h0,  9, 9, 32'h9999,     32'h9999,     32'h0,        1, 1, 1, 16'h0200, 1, 4'h0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 4'h0,  9, 0, 32'h9999,     32'h0,        32'h0,        1, 0, 0, 16'h0200, 1, 4'h0);
        vecs[14] = mk(1, 0, 32'hFF,       0, 0, 0, 0, 32'h0,        1, 4'h4,  0, 9, 32'h0,        32'h9999,     32'h9999,     0, 1, 0, 16'h0200, 1, 4'h4);
        vecs[15] = mk(1, 3, 32'h33,       0, 0, 1, 9, 32'h1234,     0, 4'h0,  9, 3, 32'h1234,     32'h33,       32'hDEADBEEF, 0, 0, 0, 16'h0000, 1, 4'h4);
        vecs[16] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 4'hA,  9, 3, 32'h1234,     32'h33,       32'h33,       0, 0, 0, 16'h0000, 1, 4'hA);

        idle();
        rd_sel1 = 0; rd_sel2 = 0;
        rst = 1'b1;
        #2;
        check("reset pending", {16'h0, pending}, 32'h0);
        check("reset flags", {28'h0, flags_out}, 32'h0);
        check("reset hazard", {31'h0, hazard_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #4;
            check($sformatf("v%0d rd_data1", i), rd_data1, vecs[i].r1);
            check($sformatf("v%0d rd_data2", i), rd_data2, vecs[i].r2);
            check($sformatf("v%0d nb rd_data2", i), nb_rd_data2, vecs[i].nb2);
            check($sformatf("v%0d rd_busy1", i), {31'h0, rd_busy1}, {31'h0, vecs[i].b1});
            check($sformatf("v%0d rd_busy2", i), {31'h0, rd_busy2}, {31'h0, vecs[i].b2});
            check($sformatf("v%0d ld_issue_ok", i), {31'h0, ld_issue_ok}, {31'h0, vecs[i].ok});
            step();
            check($sformatf("v%0d pending", i), {16'h0, pending}, {16'h0, vecs[i].p});
            check($sformatf("v%0d hazard_err", i), {31'h0, hazard_err}, {31'h0, vecs[i].h});
            check($sformatf("v%0d flags_out", i), {28'h0, flags_out}, {28'h0, vecs[i].f});
        end

        // Asynchronous reset between edges clears everything at once.
        idle();
        rd_sel1 = 9; rd_sel2 = 3;
        #2;
        rst = 1'b1;
        #1;
        check("midrst rd_data1", rd_data1, 32'h0);
        check("midrst rd_data2", rd_data2, 32'h0);
        check("midrst pending", {16'h0, pending}, 32'h0);
        check("midrst flags", {28'h0, flags_out}, 32'h0);
        check("midrst hazard", {31'h0, hazard_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Register 0: writes, issue and return are all ignored without error.
        alu_we = 1; alu_dest = 0; alu_data = 32'hFF;
        ld_issue = 1; ld_dest = 0; rd_sel1 = 0;
        #4;
        check("zr issue_ok", {31'h0, ld_issue_ok}, 32'h1);
        check("zr rd_data1", rd_data1, 32'h0);
        step();
        check("zr pending", {16'h0, pending}, 32'h0);
        check("zr hazard", {31'h0, hazard_err}, 32'h0);
        idle();
        ld_we = 1; ld_wdest = 0; ld_data = 32'h55;
        step();
        check("zr ld_we hazard", {31'h0, hazard_err}, 32'h0);
        check("zr ld_we rd_data1", rd_data1, 32'h0);

        // Load return to a non-pending register is dropped and flagged.
        idle();
        ld_we = 1; ld_wdest = 2; ld_data = 32'h77; rd_sel1 = 2;
        #4;
        check("stray ld rd_data1", rd_data1, 32'h0);
        step();
        idle();
        #1;
        check("stray ld hazard", {31'h0, hazard_err}, 32'h1);
        check("stray ld reg2", rd_data1, 32'h0);
        step();
        check("stray ld sticky", {31'h0, hazard_err}, 32'h1);

        // ALU and load to the same register in one cycle: load wins.
        pulse_reset();
        ld_issue = 1; ld_dest = 6; rd_sel1 = 6;
        step();
        idle();
        ld_we = 1; ld_wdest = 6; ld_data = 32'h66;
        alu_we = 1; alu_dest = 6; alu_data = 32'h11;
        #4;
        check("clash rd_data1 bypass", rd_data1, 32'h66);
        check("clash nb rd_data1", nb_rd_data1, 32'h0);
        step();
        idle();
        #1;
        check("clash reg6", rd_data1, 32'h66);
        check("clash hazard", {31'h0, hazard_err}, 32'h1);
        check("clash pending", {16'h0, pending}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
